instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  IF stage ahead of the IF/ID pipeline buffer. Owns the PC and issues in-order
//  reads to instruction memory over a req/ack + rvalid handshake that tolerates
//  variable latency. Buffers returned words in a small queue and presents
//  {pc_next, instr} to the IF/ID buffer. Honours the hazard-unit stall (the same
//  signal that drops the IF/ID enable) and branch/jump redirects.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  QDEPTH    2              fetch-queue entries = max outstanding+buffered words (power of 2, >=2)
//  NOP_INSTR 32'h0000_0000  word driven on instr_out when no valid entry (bubble)
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   asynchronous, active-low reset
//  stall        in   1   1 = downstream holds (IF/ID enable low); do not consume head
//  redirect     in   1   1-cycle pulse: taken branch/jump, flush and refetch
//  redirect_pc  in   32  target PC, valid with redirect
//  imem_req     out  1   read request
//  imem_addr    out  32  word address of request, stable while req && !ack
//  imem_ack     in   1   request accepted this cycle
//  imem_rvalid  in   1   read data valid, in request order
//  imem_rdata   in   32  read data
//  pc_next_out  out  32  PC+4 of head instruction -> IF/ID pc_next_in
//  instr_out    out  32  head instruction or NOP_INSTR -> IF/ID instr_in
//  fetch_valid  out  1   head entry valid
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0, state=RUN;
//   imem_req=0, imem_addr=RESET_PC, fetch_valid=0, instr_out=NOP_INSTR, pc_next_out=0.
//  Credit: imem_req=1 iff state==RUN && !redirect && (outstanding+count)<QDEPTH.
//   imem_addr=fetch_pc. On req&&ack: fetch_pc+=4 (mod 2^32, wraps silently), outstanding++.
//  Response: imem_rvalid in RUN writes {addr+4, rdata} at tail, outstanding--;
//   visible on outputs the cycle after rvalid (no bypass). Credit rule makes
//   rvalid into full queue impossible; assertion flags it.
//  Consume: head popped at edge when fetch_valid && !stall. Push+pop same cycle
//   legal at any count, count unchanged.
//  Outputs combinational from head: fetch_valid=(count!=0); if empty,
//   instr_out=NOP_INSTR and pc_next_out holds last popped value.
//  Stall: head held, outputs stable; fetching continues until credits run out.
//  FSM RUN/DRAIN:
//   RUN, redirect=1: fetch_pc<=redirect_pc, queue cleared, imem_req=0 that cycle;
//    if outstanding (after this cycle's ack/rvalid) >0: discard<=that, ->DRAIN, else stay RUN.
//   DRAIN: imem_req=0; each rvalid dropped, discard--; discard reaching 0 -> RUN.
//   DRAIN, redirect=1: fetch_pc<=redirect_pc, queue stays empty, remain DRAIN.
//  Priority: reset > redirect > stall. Redirect same cycle as rvalid drops that word.
//   Redirect same cycle as ack impossible (req=0 during redirect).
//  Redirect overrides stall: queue flushed even if stalled.
//  reset_n asserted mid-transaction: all state cleared immediately; memory must
//   be reset by the same reset_n (no stale rvalid after release).
// STRUCTURE
//  Shared package: RESET_PC default, NOP_INSTR, PC_INC=4, FSM enum {RUN,DRAIN}.
//  Sub-module fetch_queue (QDEPTH x 64-bit sync FIFO, ptr+count, push/pop/flush,
//   full/empty); top holds PC, credit counter, discard counter, FSM.
// TESTING
//  1 Reset, 1-cycle memory, stall=0 -> addrs 0,4,8,.. ; instr_out follows rdata,
//    pc_next_out 4,8,12; fetch_valid continuous after 2 cycles.
//  2 stall=1 for 5 cycles with queue full -> outputs frozen, imem_req=0 after 2 acks;
//    release -> no lost/duplicated words.
//  3 3-cycle latency, redirect to 32'h100 with 2 outstanding -> both stale words
//    dropped, next valid instr from 0x100, pc_next_out=0x104.
//  4 redirect coincident with rvalid and stall=1 -> word dropped, fetch_valid=0 next cycle.
//  5 ack held low 4 cycles -> imem_addr stable, no PC advance.
//  6 RESET_PC=32'hFFFF_FFFC -> addrs FFFF_FFFC then 0000_0000; reset_n low mid-DRAIN
//    -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: defaults, PC step, FSM states
// and the fetch-queue entry layout.
package instr_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'h0000_0004;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc_next;
    logic [31:0] instr;
  } fq_entry_t;

  // Sequential PC step; wraps silently at 2^32.
  function automatic logic [31:0] pc_advance(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_chk.sv
// Protocol checks for the fetch unit: the credit scheme must keep responses
// from ever landing in a full queue or arriving with nothing outstanding.
module instr_fetch_unit_chk (
  input logic i_clk,
  input logic i_reset_n,
  input logic i_push,
  input logic i_full,
  input logic i_rvalid,
  input logic i_no_outstanding
);

  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(i_push && i_full));

  a_no_orphan_rvalid: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(i_rvalid && i_no_outstanding));

endmodule

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Synchronous FIFO of {pc_next, instr} entries with flush; head is read
// combinationally so the IF/ID buffer sees it in the same cycle.
module instr_fetch_unit_fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  fq_entry_t     i_push_data,
  input  logic          i_pop,
  output fq_entry_t     o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  fq_entry_t     r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, issues credit-limited in-order reads to instruction
// memory, queues returned words and handles stalls and branch/jump redirects.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc_next_out,
  output logic [31:0] o_instr_out,
  output logic        o_fetch_valid
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  ifu_state_e    r_state;
  ifu_state_e    w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   r_resp_pc;
  logic [31:0]   w_resp_pc_nxt;
  logic [31:0]   r_last_pn;
  logic [31:0]   w_last_pn_nxt;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] w_outstanding_nxt;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] w_discard_nxt;
  logic [CW-1:0] w_out_after;

  fq_entry_t     w_head;
  fq_entry_t     w_push_data;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_credit_ok;
  logic          w_req;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;

  // Credits cover both in-flight requests and words already buffered.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_count}) < (CW + 1)'(QDEPTH);
  assign w_req       = (r_state == ST_RUN) && !i_redirect && w_credit_ok;
  assign w_fire      = w_req && i_imem_ack;
  assign w_push      = i_imem_rvalid && (r_state == ST_RUN) && !i_redirect;
  assign w_valid     = !w_empty;
  assign w_pop       = w_valid && !i_stall && !i_redirect;
  assign w_out_after = r_outstanding + CW'(w_fire) - CW'(i_imem_rvalid);
  assign w_push_data = '{pc_next: pc_advance(r_resp_pc), instr: i_imem_rdata};

  instr_fetch_unit_fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_flush    (i_redirect),
    .i_push     (w_push),
    .i_push_data(w_push_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Next-state logic: RUN fetches, DRAIN swallows responses to flushed requests.
  always_comb begin
    w_state_nxt       = r_state;
    w_discard_nxt     = r_discard;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_resp_pc_nxt     = r_resp_pc;
    w_outstanding_nxt = w_out_after;
    w_last_pn_nxt     = w_pop ? w_head.pc_next : r_last_pn;
    case (r_state)
      ST_RUN: begin
        if (i_redirect) begin
          w_fetch_pc_nxt = i_redirect_pc;
          w_resp_pc_nxt  = i_redirect_pc;
          if (w_out_after != '0) begin
            w_discard_nxt = w_out_after;
            w_state_nxt   = ST_DRAIN;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          if (w_fire) w_fetch_pc_nxt = pc_advance(r_fetch_pc);
          else        w_fetch_pc_nxt = r_fetch_pc;
          if (w_push) w_resp_pc_nxt = pc_advance(r_resp_pc);
          else        w_resp_pc_nxt = r_resp_pc;
        end
      end
      ST_DRAIN: begin
        if (i_imem_rvalid) begin
          w_discard_nxt = r_discard - CW'(1);
          if (r_discard == CW'(1)) w_state_nxt = ST_RUN;
          else                     w_state_nxt = ST_DRAIN;
        end else begin
          w_discard_nxt = r_discard;
        end
        if (i_redirect) begin
          w_fetch_pc_nxt = i_redirect_pc;
          w_resp_pc_nxt  = i_redirect_pc;
        end else begin
          w_fetch_pc_nxt = r_fetch_pc;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_RUN;
    else            r_state <= w_state_nxt;
  end

  // PC, response PC, credit/discard counters and last popped pc_next.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_last_pn     <= 32'h0000_0000;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_resp_pc     <= w_resp_pc_nxt;
      r_last_pn     <= w_last_pn_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
    end
  end

  assign o_imem_req    = w_req && i_reset_n;
  assign o_imem_addr   = r_fetch_pc;
  assign o_fetch_valid = w_valid;
  assign o_instr_out   = w_valid ? w_head.instr : NOP_INSTR;
  assign o_pc_next_out = w_valid ? w_head.pc_next : r_last_pn;

  instr_fetch_unit_chk u_chk (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_push          (w_push),
    .i_full          (w_full),
    .i_rvalid        (i_imem_rvalid),
    .i_no_outstanding(r_outstanding == '0)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency memory model plus a reference
// of the consumed instruction stream (sequential from PC, restarting at redirects).
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC0 = 32'h0000_0000;
  localparam logic [31:0] RST_PC1 = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk;
  logic        rst_n, stall, redirect, ack, rvalid;
  logic [31:0] redirect_pc, rdata;
  logic        req, fv;
  logic [31:0] addr, pn_o, instr_o;

  logic        rst1_n, stall1, redirect1, ack1, rvalid1;
  logic [31:0] rpc1, rdata1;
  logic        req1, fv1;
  logic [31:0] addr1, pn1, instr1;

  instr_fetch_unit #(.RESET_PC(RST_PC0), .QDEPTH(2), .NOP_INSTR(NOP)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_stall(stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ack(ack), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_pc_next_out(pn_o), .o_instr_out(instr_o), .o_fetch_valid(fv));

  instr_fetch_unit #(.RESET_PC(RST_PC1), .QDEPTH(2), .NOP_INSTR(NOP)) dut1 (
    .i_clk(clk), .i_reset_n(rst1_n), .i_stall(stall1), .i_redirect(redirect1),
    .i_redirect_pc(rpc1), .o_imem_req(req1), .o_imem_addr(addr1),
    .i_imem_ack(ack1), .i_imem_rvalid(rvalid1), .i_imem_rdata(rdata1),
    .o_pc_next_out(pn1), .o_instr_out(instr1), .o_fetch_valid(fv1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; int due; } pend_t;
  pend_t       pend[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc, lat, ack_mode, stale_left, n_ack, n_cons;
  logic [31:0] exp_pc, exp_addr, last_pn, prev_instr, prev_pn, first_pn;
  bit          prev_hold, want_first;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
  endfunction

  task automatic model_reset();
    pend.delete();
    exp_pc = RST_PC0; exp_addr = RST_PC0; last_pn = 32'h0;
    stale_left = 0; prev_hold = 1'b0; n_ack = 0; n_cons = 0; cyc = 0;
    want_first = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ack = 1'b0; rvalid = 1'b0; rdata = 32'h0; ack_mode = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: memory responds, scoreboard checks, then advance to next negedge.
  task automatic step();
    bit    rv;
    pend_t p;
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    rvalid = rv;
    if (rv) rdata = mem_word(pend[0].a);
    else    rdata = 32'h0;
    case (ack_mode)
      0:       ack = 1'b1;
      1:       ack = 1'($urandom_range(0, 1));
      default: ack = 1'b0;
    endcase
    #1;
    if (redirect || stale_left > 0) begin
      n_tests++;
      if (req !== 1'b0) begin n_fail++; $display("FAIL req_blocked cyc=%0d got=%b want=0", cyc, req); end
    end
    if (fv !== 1'b1) begin
      n_tests++;
      if (instr_o !== NOP || pn_o !== last_pn) begin
        n_fail++;
        $display("FAIL bubble cyc=%0d instr=%h want=%h pc_next=%h want=%h", cyc, instr_o, NOP, pn_o, last_pn);
      end
    end
    if (prev_hold) begin
      n_tests++;
      if (fv !== 1'b1 || instr_o !== prev_instr || pn_o !== prev_pn) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got=%b/%h/%h want=1/%h/%h", cyc, fv, instr_o, pn_o, prev_instr, prev_pn);
      end
    end
    if (req === 1'b1 && ack) begin
      n_tests++;
      if (addr !== exp_addr) begin n_fail++; $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, addr, exp_addr); end
      p.a = addr; p.due = cyc + lat;
      pend.push_back(p);
      exp_addr = exp_addr + 32'd4;
      n_ack++;
    end
    if (rv) begin
      void'(pend.pop_front());
      if (stale_left > 0) stale_left--;
    end
    if (fv === 1'b1 && !stall && !redirect) begin
      n_tests++;
      if (instr_o !== mem_word(exp_pc) || pn_o !== exp_pc + 32'd4) begin
        n_fail++;
        $display("FAIL consume cyc=%0d instr=%h want=%h pc_next=%h want=%h", cyc, instr_o, mem_word(exp_pc), pn_o, exp_pc + 32'd4);
      end
      if (want_first) begin first_pn = pn_o; want_first = 1'b0; end
      last_pn = exp_pc + 32'd4;
      exp_pc  = exp_pc + 32'd4;
      n_cons++;
    end
    prev_hold  = (fv === 1'b1) && stall && !redirect;
    prev_instr = instr_o;
    prev_pn    = pn_o;
    if (redirect) begin
      exp_pc = redirect_pc; exp_addr = redirect_pc; stale_left = pend.size();
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; ack = 1'b0; rvalid = 1'b0;
    model_reset();
    @(negedge clk); #1;
    n_tests++;
    if (req !== 1'b0 || addr !== RST_PC0 || fv !== 1'b0 || instr_o !== NOP || pn_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values req=%b addr=%h fv=%b instr=%h pn=%h", req, addr, fv, instr_o, pn_o);
    end
    @(negedge clk);
    rst_n = 1'b1; #1;
    n_tests++;
    if (req !== 1'b1) begin n_fail++; $display("FAIL req_after_reset got=%b want=1", req); end
    @(negedge clk);
  endtask

  task automatic test_sequential();
    do_reset(); lat = 1;
    repeat (40) step();
    n_tests++;
    if (n_cons < 20) begin n_fail++; $display("FAIL seq_throughput got=%0d want>=20", n_cons); end
  endtask

  task automatic test_stall();
    do_reset(); lat = 1; stall = 1'b1;
    repeat (5) step();
    #1;
    n_tests++;
    if (n_ack != 2 || req !== 1'b0 || fv !== 1'b1) begin
      n_fail++; $display("FAIL stall_credit acks=%0d req=%b fv=%b want=2/0/1", n_ack, req, fv);
    end
    stall = 1'b0;
    repeat (20) step();
    n_tests++;
    if (n_cons < 8) begin n_fail++; $display("FAIL stall_release consumed=%0d want>=8", n_cons); end
  endtask

  task automatic test_redirect_drain();
    do_reset(); lat = 3;
    repeat (2) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0; want_first = 1'b1;
    for (int i = 0; i < 30 && want_first; i++) step();
    n_tests++;
    if (want_first || first_pn !== 32'h0000_0104) begin
      n_fail++; $display("FAIL redirect_first_pc_next got=%h want=00000104 timeout=%b", first_pn, want_first);
    end
  endtask

  task automatic test_redirect_rvalid_stall();
    bit done;
    do_reset(); lat = 1; stall = 1'b1; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (fv === 1'b1 && pend.size() > 0 && pend[0].due <= cyc) begin
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0; done = 1'b1;
        #1;
        n_tests++;
        if (fv !== 1'b0) begin n_fail++; $display("FAIL redirect_drop_fv got=%b want=0", fv); end
      end else begin
        step();
      end
    end
    if (!done) begin n_tests++; n_fail++; $display("FAIL redirect_rvalid_setup timeout got=0 want=1"); end
    stall = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_ack_hold();
    logic [31:0] a0;
    do_reset(); lat = 2;
    repeat (6) step();
    ack_mode = 2; a0 = addr;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      n_tests++;
      if (addr !== a0) begin n_fail++; $display("FAIL ack_hold_addr i=%0d got=%h want=%h", i, addr, a0); end
    end
    n_tests++;
    if (req !== 1'b1) begin n_fail++; $display("FAIL ack_hold_req got=%b want=1", req); end
    ack_mode = 0;
    repeat (10) step();
  endtask

  task automatic test_wrap();
    rst1_n = 1'b0; ack1 = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (addr1 !== RST_PC1 || req1 !== 1'b0) begin n_fail++; $display("FAIL wrap_reset addr=%h req=%b want=fffffffc/0", addr1, req1); end
    @(negedge clk);
    rst1_n = 1'b1; ack1 = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (addr1 !== 32'h0000_0000 || req1 !== 1'b1) begin n_fail++; $display("FAIL wrap_addr0 addr=%h req=%b want=00000000/1", addr1, req1); end
    @(negedge clk); #1;
    n_tests++;
    if (addr1 !== 32'h0000_0004 || req1 !== 1'b0) begin n_fail++; $display("FAIL wrap_addr4 addr=%h req=%b want=00000004/0", addr1, req1); end
    ack1 = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    do_reset(); lat = 1;
    repeat (10) step();
    lat = 4;
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect = 1'b0;
    #2;
    rst_n = 1'b0; rvalid = 1'b0; ack = 1'b0;
    #1;
    n_tests++;
    if (req !== 1'b0 || addr !== RST_PC0 || fv !== 1'b0 || instr_o !== NOP || pn_o !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset req=%b addr=%h fv=%b instr=%h pn=%h", req, addr, fv, instr_o, pn_o);
    end
    model_reset(); lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step();
    n_tests++;
    if (n_cons < 4) begin n_fail++; $display("FAIL post_reset_stream consumed=%0d want>=4", n_cons); end
  endtask

  task automatic test_random();
    do_reset(); ack_mode = 1;
    for (int s = 0; s < 10; s++) begin
      lat = int'($urandom_range(1, 4));
      for (int i = 0; i < 150; i++) begin
        stall       = ($urandom_range(0, 3) == 0);
        redirect    = ($urandom_range(0, 15) == 0);
        redirect_pc = $urandom() & 32'hFFFF_FFFC;
        step();
      end
    end
    stall = 1'b0; redirect = 1'b0;
    n_tests++;
    if (n_cons < 100) begin n_fail++; $display("FAIL random_progress consumed=%0d want>=100", n_cons); end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout reached got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ack = 1'b0; rvalid = 1'b0; rdata = 32'h0; lat = 1; ack_mode = 0;
    rst1_n = 1'b0; stall1 = 1'b1; redirect1 = 1'b0; rpc1 = 32'h0;
    ack1 = 1'b0; rvalid1 = 1'b0; rdata1 = 32'h0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drain();
    test_redirect_rvalid_stall();
    test_ack_hold();
    test_wrap();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
